// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch controller for the 5-stage ARM pipeline.
// Owns the fetch PC and drives a synchronous-read instruction memory with
// one-cycle read latency. Delivers one instruction per cycle to IF/ID using a
// valid/stall handshake. Handles branch redirect and flush, halts on an
// out-of-range fetch, and counts accepted instructions.
//
// Ports:
//   clk_i, reset_i       clock and synchronous active-high reset
//   stall_i              downstream cannot accept this cycle
//   branch_valid_i       redirect request from execute
//   branch_target_i      redirect byte address (low two bits ignored)
//   mem_pc_o             fetch byte address to instruction memory
//   mem_read_en_o        instruction memory read enable
//   mem_instr_i          instruction memory read data
//   instr_o              fetched instruction, or NOP_INSTR while invalid
//   instr_pc_o           byte address of instr_o
//   instr_valid_o        instr_o is a real instruction
//   halt_o               controller is halted
//   fetch_count_o        count of instructions accepted downstream
//
// State | meaning
// BOOT  | one idle cycle after reset, no read issued
// RUN   | fetching sequentially, honouring stall and branch
// HALT  | fetch ran past the end of memory; waits for a branch
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 512,
  parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        branch_valid_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] mem_pc_o,
  output logic        mem_read_en_o,
  input  logic [31:0] mem_instr_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_valid_o,
  output logic        halt_o,
  output logic [31:0] fetch_count_o
);

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] count_q, count_d;
  logic        valid_q, valid_d;
  logic        rd_en;
  logic [31:0] target_aligned;

  assign target_aligned = {branch_target_i[31:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    count_d    = count_q;
    rd_en      = 1'b0;

    // An instruction presented alongside a branch is still consumed.
    if (valid_q && !stall_i) begin
      count_d = count_q + 32'd1;
    end

    case (state_q)
      S_BOOT: begin
        if (branch_valid_i) begin
          pc_d = target_aligned;
        end
        state_d = S_RUN;
      end
      S_RUN: begin
        if (branch_valid_i) begin
          pc_d    = target_aligned;
          valid_d = 1'b0;
        end else if (stall_i) begin
          // Read enable stays low so the memory keeps presenting instr_o.
        end else if (pc_q > LAST_PC) begin
          valid_d = 1'b0;
          state_d = S_HALT;
        end else begin
          rd_en      = 1'b1;
          pc_d       = pc_q + 32'd4;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
        end
      end
      S_HALT: begin
        valid_d = 1'b0;
        if (branch_valid_i) begin
          pc_d    = target_aligned;
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      instr_pc_q <= 32'h0;
      valid_q    <= 1'b0;
      count_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
    end
  end

  assign mem_pc_o      = pc_q;
  assign mem_read_en_o = rd_en;
  assign instr_o       = valid_q ? mem_instr_i : NOP_INSTR;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = valid_q;
  assign halt_o        = (state_q == S_HALT);
  assign fetch_count_o = count_q;

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller for the 5-stage ARM pipeline. Owns the fetch PC and sequences the byte-addressed, synchronous-read instruction memory (one-cycle read latency, output held while read enable is low). Presents one instruction per cycle to the IF/ID register with a valid/stall handshake. Handles branch redirect/flush, halts on an out-of-range fetch, and counts delivered instructions.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset (word-aligned).
- MEM_BYTES, 512, instruction memory size in bytes; legal fetch PCs are 0..MEM_BYTES-4.
- NOP_INSTR, 32'hE1A0_0000, instruction driven while invalid (ARM `mov r0,r0`).

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- reset_i  in  1  synchronous, active-high reset.
- stall_i  in  1  downstream cannot accept this cycle.
- branch_valid_i  in  1  redirect request from execute.
- branch_target_i  in  32  redirect byte address.
- mem_pc_o  out  32  byte address to instruction memory (= pc_q).
- mem_read_en_o  out  1  instruction memory read enable.
- mem_instr_i  in  32  instruction memory read data.
- instr_o  out  32  mem_instr_i when instr_valid_o=1, else NOP_INSTR.
- instr_pc_o  out  32  byte address of instr_o.
- instr_valid_o  out  1  instr_o is a real instruction.
- halt_o  out  1  controller in HALT.
- fetch_count_o  out  32  instructions accepted downstream.

## Operation

- State register: BOOT, RUN, HALT. Reset -> BOOT.
- BOOT: mem_read_en_o=0; next state RUN (one idle cycle after reset). branch_valid_i in BOOT: pc_q loads target, still -> RUN.
- RUN, per cycle, priority order:
  1. branch_valid_i=1: pc_q <= {branch_target_i[31:2],2'b00}; instr_valid_o <= 0; mem_read_en_o=0; stays RUN. Overrides stall_i.
  2. stall_i=1: mem_read_en_o=0; pc_q, instr_pc_o, instr_valid_o hold; memory output holds, so instr_o is stable.
  3. pc_q > MEM_BYTES-4: mem_read_en_o=0; instr_valid_o <= 0; -> HALT.
  4. Otherwise issue: mem_read_en_o=1; pc_q <= pc_q+4 (32-bit modular); instr_pc_o <= pc_q; instr_valid_o <= 1.
- HALT: mem_read_en_o=0, halt_o=1, instr_valid_o=0. branch_valid_i=1 loads aligned target and -> RUN; otherwise stay.
- Acceptance: a cycle with instr_valid_o=1 and stall_i=0. fetch_count_o increments by 1 on acceptance (wraps at 2^32), including when branch_valid_i is also high (instruction is consumed before flush).
- mem_read_en_o, halt_o, instr_o are combinational from state/registers/stall_i/branch_valid_i; no combinational path from branch_target_i to mem_pc_o.

## Timing

- Reset values (cycle after reset_i sampled high): state BOOT, pc_q=RESET_PC, mem_pc_o=RESET_PC, mem_read_en_o=0, instr_valid_o=0, instr_o=NOP_INSTR, instr_pc_o=0, halt_o=0, fetch_count_o=0. Reset mid-stall, mid-branch or in HALT behaves identically.
- First read issues in cycle 2 after reset deassertion (BOOT occupies cycle 1); first instr_valid_o=1 in cycle 3.
- Read latency: issue in cycle t -> instr_valid_o=1, instr_pc_o=issued address, instr_o=word in cycle t+1.
- Unstalled throughput: one instruction per cycle, PCs ascending by 4.
- Branch penalty: branch_valid_i in cycle t -> instr_valid_o=0 in t+1, target read issued in t+1, target instruction valid in t+2.
- Stall release: stall_i falls in cycle t -> next read issues in t, held instruction accepted in t.

## Test plan

- Reset/boot: memory words 0x0:E3A00001, 0x4:E3A01002, 0x8:E0802001; release reset -> cycle 3 instr=E3A00001 pc=0, cycle 4 E3A01002 pc=4, cycle 5 E0802001 pc=8; fetch_count_o=3 after cycle 5.
- Stall hold: stall_i=1 for 3 cycles while pc=4 valid -> instr_o=E3A01002, instr_pc_o=4, mem_read_en_o=0 throughout; fetch_count_o unchanged; on release next pc=8.
- Branch flush: branch_valid_i=1, target=0x0000_0012 while pc=8 valid -> next cycle valid=0, instr_o=E1A00000, mem_pc_o=0x10; following cycle instr_pc_o=0x10, valid=1. Repeat with stall_i=1 simultaneously -> same result.
- Out-of-range halt: run sequentially to pc=0x1FC -> word 0x1FC delivered, next cycle halt_o=1, valid=0, no further reads; branch to 0x0 -> halt_o=0, instruction at 0 valid two cycles later.
- Branch to out-of-range target 0x200 -> one cycle RUN with no read, then halt_o=1.
- Reset mid-operation: assert reset_i during stall with valid=1 -> next cycle all outputs at reset values, fetch_count_o=0.
